// File: rtl/sram_obi_adapter_pkg.sv
// sram_obi_adapter_pkg: shared types and helpers for the OBI-to-SRAM bank adapter.
// Holds the retention FSM state encoding and width helpers used for the
// adapter's address and counter sizing.

package sram_obi_adapter_pkg;

  // Retention FSM states. The bank is only accessible in ACTIVE.
  typedef enum logic [1:0] {
    ACTIVE = 2'd0,
    RET    = 2'd1,
    WAKE   = 2'd2
  } ret_state_e;

  localparam int unsigned DataWidth = 32;
  localparam int unsigned BeWidth   = DataWidth / 8;

  // ceil(log2(n)) but never below 1, so that a single-entry range still
  // gets a one-bit signal instead of a zero-width one.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Width needed to hold every value from 0 up to and including max_val.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/sram_obi_adapter.sv
// sram_obi_adapter: single-bank OBI slave front-end for sram_wrapper.
//
// Passes OBI requests straight through to the SRAM macro port (zero-cycle
// grant, word-aligned address, one-cycle rvalid) and runs an idle-driven
// retention FSM. After IdleCycles consecutive idle cycles with retention
// enabled, the bank is put into retention; a new request (or software
// disabling retention) releases it, and grants are held off for WakeCycles
// cycles while the bank wakes up.
//
// Build option: define SRAM_OBI_ADAPTER_RET_CNT_EN to build a saturating
// 32-bit counter of cycles spent in retention on ret_cycles_o. Without it
// the port is tied to zero and no counter flops exist.

module sram_obi_adapter
  import sram_obi_adapter_pkg::*;
#(
  parameter int unsigned NumWords   = 1024,
  parameter int unsigned IdleCycles = 64,
  parameter int unsigned WakeCycles = 2,
  localparam int unsigned AddrWidth = clog2_min1(NumWords)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 retention_en_i,
  // OBI slave port
  input  logic                 req_i,
  output logic                 gnt_o,
  input  logic                 we_i,
  input  logic [3:0]           be_i,
  input  logic [31:0]          addr_i,
  input  logic [31:0]          wdata_i,
  output logic                 rvalid_o,
  output logic [31:0]          rdata_o,
  // SRAM macro port (towards sram_wrapper)
  output logic                 sram_req_o,
  output logic                 sram_we_o,
  output logic [AddrWidth-1:0] sram_addr_o,
  output logic [31:0]          sram_wdata_o,
  output logic [3:0]           sram_be_o,
  output logic                 sram_set_retentive_o,
  input  logic [31:0]          sram_rdata_i,
  // Retention statistics
  output logic [31:0]          ret_cycles_o
);

  localparam int unsigned IdleW = cnt_width(IdleCycles);
  localparam int unsigned WakeW = clog2_min1(WakeCycles);

  localparam logic [IdleW-1:0] IdleLast = IdleW'(IdleCycles - 1);
  localparam logic [IdleW-1:0] IdleMax  = IdleW'(IdleCycles);
  localparam logic [WakeW-1:0] WakeLast = WakeW'(WakeCycles - 1);

  ret_state_e       state_q;
  logic [IdleW-1:0] idle_cnt_q;
  logic [WakeW-1:0] wake_cnt_q;
  logic             set_ret_q;
  logic             rvalid_q;

  logic active;
  logic wake_up;
  logic idle_hit;

  assign active  = (state_q == ACTIVE);
  // A pending request or software withdrawing the enable both end retention.
  assign wake_up = req_i | ~retention_en_i;
  // Last idle cycle before retention; a request arriving in this very cycle
  // wins and keeps the bank awake.
  assign idle_hit = retention_en_i & ~req_i & (idle_cnt_q == IdleLast);

  // ---------------------------------------------------------------------------
  // Request path: the bank is only visible to the bus while ACTIVE.
  // ---------------------------------------------------------------------------
  assign gnt_o        = active & req_i;
  assign sram_req_o   = active & req_i;
  assign sram_we_o    = we_i;
  assign sram_be_o    = be_i;
  assign sram_wdata_o = wdata_i;
  // Byte address to word address; bits above the bank size are ignored.
  assign sram_addr_o  = addr_i[AddrWidth+1:2];

  assign sram_set_retentive_o = set_ret_q;

  // Byte-offset and out-of-bank address bits are intentionally dropped.
  logic unused_addr;
  assign unused_addr = ^{addr_i[31:AddrWidth+2], addr_i[1:0]};

  // Retention FSM with its idle/wake counters and registered retention output.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ACTIVE;
      idle_cnt_q <= '0;
      wake_cnt_q <= '0;
      set_ret_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every branch sees the pre-edge
      // values of state_q and the counters, regardless of statement order.
      case (state_q)
        ACTIVE: begin
          if (wake_up) begin
            idle_cnt_q <= '0;
          end else if (idle_hit) begin
            state_q    <= RET;
            set_ret_q  <= 1'b1;
            idle_cnt_q <= '0;
          end else if (idle_cnt_q != IdleMax) begin
            idle_cnt_q <= idle_cnt_q + 1'b1;
          end
        end
        RET: begin
          if (wake_up) begin
            state_q    <= WAKE;
            set_ret_q  <= 1'b0;
            wake_cnt_q <= '0;
          end
        end
        WAKE: begin
          // Wake always runs to completion, even if the enable drops.
          if (wake_cnt_q == WakeLast) begin
            state_q    <= ACTIVE;
            wake_cnt_q <= '0;
          end else begin
            wake_cnt_q <= wake_cnt_q + 1'b1;
          end
        end
        default: begin
          state_q    <= ACTIVE;
          set_ret_q  <= 1'b0;
          idle_cnt_q <= '0;
          wake_cnt_q <= '0;
        end
      endcase
    end
  end

  // Response valid: one cycle after every grant, reads and writes alike.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= gnt_o;
    end
  end

  assign rvalid_o = rvalid_q;
  // NOTE: a continuous assign with an explicit else value cannot infer a
  // latch; the zero keeps stale macro data off the bus between responses.
  assign rdata_o  = rvalid_q ? sram_rdata_i : 32'h0;

  // ---------------------------------------------------------------------------
  // Optional retention-cycle statistics.
  // ---------------------------------------------------------------------------
`ifdef SRAM_OBI_ADAPTER_RET_CNT_EN
  logic [31:0] ret_cnt_q;

  // Count cycles spent in RET, saturating at all-ones; cleared only by reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ret_cnt_q <= '0;
    end else if ((state_q == RET) && (ret_cnt_q != 32'hFFFF_FFFF)) begin
      ret_cnt_q <= ret_cnt_q + 32'd1;
    end
  end

  assign ret_cycles_o = ret_cnt_q;
`else
  assign ret_cycles_o = 32'h0;
`endif

endmodule

// File: tb/tb_sram_obi_adapter.sv
// tb_sram_obi_adapter: self-checking bench for sram_obi_adapter.
// A behavioural bank (array with byte enables) sits on the SRAM port and a
// separate reference memory predicts every read value from the transaction
// history; retention timing is predicted from idle/wake cycle counts.

module tb_sram_obi_adapter;

  localparam int unsigned NUM_WORDS   = 1024;
  localparam int unsigned IDLE_CYCLES = 64;
  localparam int unsigned WAKE_CYCLES = 2;
  localparam int unsigned AW          = 10;
`ifdef SRAM_OBI_ADAPTER_RET_CNT_EN
  localparam logic [31:0] EXP_RET_CYCLES = 32'd10;
`else
  localparam logic [31:0] EXP_RET_CYCLES = 32'd0;
`endif

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          retention_en_i;
  logic          req_i;
  logic          gnt_o;
  logic          we_i;
  logic [3:0]    be_i;
  logic [31:0]   addr_i;
  logic [31:0]   wdata_i;
  logic          rvalid_o;
  logic [31:0]   rdata_o;
  logic          sram_req_o;
  logic          sram_we_o;
  logic [AW-1:0] sram_addr_o;
  logic [31:0]   sram_wdata_o;
  logic [3:0]    sram_be_o;
  logic          sram_set_retentive_o;
  logic [31:0]   sram_rdata_i = 32'h0;
  logic [31:0]   ret_cycles_o;

  int checks = 0;
  int errors = 0;

  sram_obi_adapter #(
    .NumWords  (NUM_WORDS),
    .IdleCycles(IDLE_CYCLES),
    .WakeCycles(WAKE_CYCLES)
  ) dut (
    .clk_i               (clk_i),
    .rst_ni              (rst_ni),
    .retention_en_i      (retention_en_i),
    .req_i               (req_i),
    .gnt_o               (gnt_o),
    .we_i                (we_i),
    .be_i                (be_i),
    .addr_i              (addr_i),
    .wdata_i             (wdata_i),
    .rvalid_o            (rvalid_o),
    .rdata_o             (rdata_o),
    .sram_req_o          (sram_req_o),
    .sram_we_o           (sram_we_o),
    .sram_addr_o         (sram_addr_o),
    .sram_wdata_o        (sram_wdata_o),
    .sram_be_o           (sram_be_o),
    .sram_set_retentive_o(sram_set_retentive_o),
    .sram_rdata_i        (sram_rdata_i),
    .ret_cycles_o        (ret_cycles_o)
  );

  always #5 clk_i = ~clk_i;

  // Behavioural SRAM bank: one-cycle read latency, byte-enabled writes.
  logic [31:0] sram_mem [NUM_WORDS];
  always @(posedge clk_i) begin
    if (sram_req_o) begin
      if (sram_we_o) begin
        for (int b = 0; b < 4; b++)
          if (sram_be_o[b]) sram_mem[sram_addr_o][8*b +: 8] <= sram_wdata_o[8*b +: 8];
      end else begin
        sram_rdata_i <= sram_mem[sram_addr_o];
      end
    end
  end

  // Reference model: what the bank should contain, in bus order.
  logic [31:0] ref_mem [NUM_WORDS];

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp;
  } txn_t;

  txn_t q[$];

  function automatic int unsigned word_index(input logic [31:0] a);
    return (a / 32'd4) % NUM_WORDS;
  endfunction

  // Queue a transfer and predict its read data from the reference memory.
  function automatic void add_txn(input logic we, input logic [31:0] addr,
                                  input logic [31:0] wdata, input logic [3:0] be);
    txn_t        t;
    logic [31:0] mask;
    int unsigned idx;
    idx     = word_index(addr);
    mask    = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    t.we    = we;
    t.addr  = addr;
    t.wdata = wdata;
    t.be    = be;
    t.exp   = ref_mem[idx];
    if (we) ref_mem[idx] = (ref_mem[idx] & ~mask) | (wdata & mask);
    q.push_back(t);
  endfunction

  task automatic idle_inputs();
    req_i   = 1'b0;
    we_i    = 1'b0;
    be_i    = 4'h0;
    addr_i  = 32'h0;
    wdata_i = 32'h0;
  endtask

  // Assert reset for two cycles and release it on a falling edge.
  task automatic do_reset(input logic en);
    @(negedge clk_i);
    rst_ni = 1'b0;
    idle_inputs();
    retention_en_i = en;
    @(negedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  // Issue every queued transfer on consecutive cycles and check grant,
  // SRAM-side fields and the response of the previous transfer each cycle.
  task automatic run_burst();
    int n = q.size();
    for (int k = 0; k <= n; k++) begin
      @(posedge clk_i); #1;
      if (k < n) begin
        req_i = 1'b1; we_i = q[k].we; addr_i = q[k].addr;
        wdata_i = q[k].wdata; be_i = q[k].be;
      end else begin
        idle_inputs();
      end
      @(negedge clk_i);
      if (k < n) begin
        checks++;
        if (gnt_o !== 1'b1 || sram_req_o !== 1'b1) begin
          errors++; $display("FAIL gnt[%0d]: got gnt=%b sram_req=%b expected 1/1", k, gnt_o, sram_req_o);
        end
        checks++;
        if (sram_addr_o !== AW'(word_index(q[k].addr))) begin
          errors++; $display("FAIL sram_addr[%0d]: got %0h expected %0h", k, sram_addr_o, word_index(q[k].addr));
        end
        checks++;
        if (sram_we_o !== q[k].we || sram_be_o !== q[k].be || sram_wdata_o !== q[k].wdata) begin
          errors++; $display("FAIL sram_fields[%0d]: got we=%b be=%h wd=%h expected we=%b be=%h wd=%h",
                             k, sram_we_o, sram_be_o, sram_wdata_o, q[k].we, q[k].be, q[k].wdata);
        end
      end
      if (k > 0) begin
        checks++;
        if (rvalid_o !== 1'b1) begin
          errors++; $display("FAIL rvalid[%0d]: got %b expected 1", k - 1, rvalid_o);
        end
        if (!q[k-1].we) begin
          checks++;
          if (rdata_o !== q[k-1].exp) begin
            errors++; $display("FAIL rdata[%0d]: got %h expected %h", k - 1, rdata_o, q[k-1].exp);
          end
        end
      end
    end
    @(negedge clk_i);
    checks++;
    if (rvalid_o !== 1'b0 || rdata_o !== 32'h0) begin
      errors++; $display("FAIL idle_response: got rvalid=%b rdata=%h expected 0/0", rvalid_o, rdata_o);
    end
    q.delete();
  endtask

  // Wait (bounded) for retention entry; returns the number of rising edges seen.
  task automatic wait_retention(output int n);
    n = 0;
    while (n < 200) begin
      @(posedge clk_i);
      n++;
      @(negedge clk_i);
      if (sram_set_retentive_o === 1'b1) break;
    end
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    retention_en_i = 1'b0;
    idle_inputs();
    #3;
    checks++;
    if (gnt_o !== 1'b0 || rvalid_o !== 1'b0 || rdata_o !== 32'h0 || sram_req_o !== 1'b0 ||
        sram_set_retentive_o !== 1'b0 || ret_cycles_o !== 32'h0) begin
      errors++; $display("FAIL reset_values: got gnt=%b rvalid=%b rdata=%h sreq=%b ret=%b cyc=%h expected all 0",
                         gnt_o, rvalid_o, rdata_o, sram_req_o, sram_set_retentive_o, ret_cycles_o);
    end
    do_reset(1'b0);
  endtask

  task automatic test_write_read();
    add_txn(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF);
    run_burst();
    add_txn(1'b0, 32'h10, 32'h0, 4'hF);
    run_burst();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) add_txn(1'b1, 32'(4 * i), $urandom(), 4'hF);
    run_burst();
    for (int i = 0; i < 3; i++) add_txn(1'b0, 32'(4 * i), 32'h0, 4'hF);
    run_burst();
  endtask

  task automatic test_random();
    for (int b = 0; b < 4; b++) begin
      for (int i = 0; i < 6; i++)
        add_txn(1'($urandom_range(0, 1)), $urandom() & 32'hFFFF_F03F, $urandom(),
                4'($urandom_range(0, 15)));
      run_burst();
    end
  endtask

  task automatic test_idle_retention();
    int n;
    int w;
    logic bad;
    do_reset(1'b1);
    wait_retention(n);
    checks++;
    if (n != IDLE_CYCLES) begin
      errors++; $display("FAIL ret_entry_cycles: got %0d expected %0d", n, IDLE_CYCLES);
    end
    @(posedge clk_i); #1;
    req_i = 1'b1; we_i = 1'b0; addr_i = 32'h10; be_i = 4'hF;
    @(negedge clk_i);
    checks++;
    if (gnt_o !== 1'b0 || sram_req_o !== 1'b0 || sram_set_retentive_o !== 1'b1) begin
      errors++; $display("FAIL ret_blocks: got gnt=%b sreq=%b ret=%b expected 0/0/1",
                         gnt_o, sram_req_o, sram_set_retentive_o);
    end
    w = 0; bad = 1'b0;
    while (w < 20) begin
      @(posedge clk_i);
      w++;
      @(negedge clk_i);
      if (gnt_o === 1'b1) break;
      if (sram_set_retentive_o !== 1'b0 || sram_req_o !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (w != WAKE_CYCLES + 1) begin
      errors++; $display("FAIL wake_latency: got %0d expected %0d", w, WAKE_CYCLES + 1);
    end
    checks++;
    if (bad) begin
      errors++; $display("FAIL wake_outputs: got retentive/sram_req high in WAKE expected 0");
    end
    @(posedge clk_i); #1;
    idle_inputs();
    @(negedge clk_i);
    checks++;
    if (rvalid_o !== 1'b1 || rdata_o !== ref_mem[4]) begin
      errors++; $display("FAIL wake_read: got rvalid=%b rdata=%h expected 1/%h", rvalid_o, rdata_o, ref_mem[4]);
    end
  endtask

  task automatic test_threshold();
    logic bad;
    do_reset(1'b1);
    repeat (IDLE_CYCLES - 1) @(posedge clk_i);
    #1;
    req_i = 1'b1; we_i = 1'b0; addr_i = 32'h8; be_i = 4'hF;
    @(negedge clk_i);
    checks++;
    if (gnt_o !== 1'b1 || sram_set_retentive_o !== 1'b0) begin
      errors++; $display("FAIL threshold_grant: got gnt=%b ret=%b expected 1/0", gnt_o, sram_set_retentive_o);
    end
    @(posedge clk_i); #1;
    idle_inputs();
    @(negedge clk_i);
    checks++;
    if (rvalid_o !== 1'b1 || rdata_o !== ref_mem[2] || sram_set_retentive_o !== 1'b0) begin
      errors++; $display("FAIL threshold_resp: got rvalid=%b rdata=%h ret=%b expected 1/%h/0",
                         rvalid_o, rdata_o, sram_set_retentive_o, ref_mem[2]);
    end
    bad = 1'b0;
    repeat (IDLE_CYCLES - 2) begin
      @(negedge clk_i);
      if (sram_set_retentive_o !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++; $display("FAIL idle_restart: got retention before a fresh idle window expected 0");
    end
  endtask

  task automatic test_ret_disabled();
    int n;
    int w;
    logic bad;
    do_reset(1'b0);
    bad = 1'b0;
    repeat (200) begin
      @(negedge clk_i);
      if (sram_set_retentive_o !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++; $display("FAIL ret_disabled: got retentive=1 with enable low expected 0");
    end
    retention_en_i = 1'b1;
    wait_retention(n);
    checks++;
    if (n != IDLE_CYCLES) begin
      errors++; $display("FAIL ret_reentry_cycles: got %0d expected %0d", n, IDLE_CYCLES);
    end
    @(posedge clk_i); #1;
    retention_en_i = 1'b0;
    @(posedge clk_i);
    @(negedge clk_i);
    checks++;
    if (sram_set_retentive_o !== 1'b0 || gnt_o !== 1'b0) begin
      errors++; $display("FAIL disable_exit: got ret=%b gnt=%b expected 0/0", sram_set_retentive_o, gnt_o);
    end
    req_i = 1'b1; we_i = 1'b0; addr_i = 32'h0; be_i = 4'hF;
    w = 0; bad = 1'b0;
    while (w < 20) begin
      @(posedge clk_i);
      w++;
      @(negedge clk_i);
      if (gnt_o === 1'b1) break;
      if (sram_set_retentive_o !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (w != WAKE_CYCLES || bad) begin
      errors++; $display("FAIL disable_wake: got %0d edges bad=%b expected %0d/0", w, bad, WAKE_CYCLES);
    end
    @(posedge clk_i); #1;
    idle_inputs();
    @(negedge clk_i);
    checks++;
    if (rvalid_o !== 1'b1 || rdata_o !== ref_mem[0]) begin
      errors++; $display("FAIL disable_read: got rvalid=%b rdata=%h expected 1/%h", rvalid_o, rdata_o, ref_mem[0]);
    end
  endtask

  task automatic test_reset_in_ret();
    int n;
    do_reset(1'b1);
    wait_retention(n);
    repeat (10) @(posedge clk_i);
    @(negedge clk_i);
    checks++;
    if (ret_cycles_o !== EXP_RET_CYCLES) begin
      errors++; $display("FAIL ret_cycles: got %0d expected %0d", ret_cycles_o, EXP_RET_CYCLES);
    end
    #2;
    rst_ni = 1'b0;
    #1;
    checks++;
    if (sram_set_retentive_o !== 1'b0 || ret_cycles_o !== 32'h0 || gnt_o !== 1'b0 || rvalid_o !== 1'b0) begin
      errors++; $display("FAIL reset_in_ret: got ret=%b cyc=%0d gnt=%b rvalid=%b expected 0/0/0/0",
                         sram_set_retentive_o, ret_cycles_o, gnt_o, rvalid_o);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    req_i = 1'b1; we_i = 1'b0; addr_i = 32'h4; be_i = 4'hF;
    #1;
    checks++;
    if (gnt_o !== 1'b1) begin
      errors++; $display("FAIL restart_active: got gnt=%b expected 1", gnt_o);
    end
    @(posedge clk_i); #1;
    idle_inputs();
    wait_retention(n);
    @(posedge clk_i); #1;
    req_i = 1'b1;
    @(posedge clk_i); #2;
    checks++;
    if (sram_set_retentive_o !== 1'b0 || gnt_o !== 1'b0) begin
      errors++; $display("FAIL in_wake: got ret=%b gnt=%b expected 0/0", sram_set_retentive_o, gnt_o);
    end
    rst_ni = 1'b0;
    idle_inputs();
    #1;
    checks++;
    if (sram_set_retentive_o !== 1'b0 || ret_cycles_o !== 32'h0 || rvalid_o !== 1'b0 || sram_req_o !== 1'b0) begin
      errors++; $display("FAIL reset_in_wake: got ret=%b cyc=%0d rvalid=%b sreq=%b expected 0/0/0/0",
                         sram_set_retentive_o, ret_cycles_o, rvalid_o, sram_req_o);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    req_i = 1'b1; we_i = 1'b0; addr_i = 32'h4; be_i = 4'hF;
    #1;
    checks++;
    if (gnt_o !== 1'b1) begin
      errors++; $display("FAIL restart_after_wake: got gnt=%b expected 1", gnt_o);
    end
    @(posedge clk_i); #1;
    idle_inputs();
    @(negedge clk_i);
    checks++;
    if (rvalid_o !== 1'b1 || rdata_o !== ref_mem[1]) begin
      errors++; $display("FAIL restart_read: got rvalid=%b rdata=%h expected 1/%h", rvalid_o, rdata_o, ref_mem[1]);
    end
  endtask

  initial begin
    for (int i = 0; i < NUM_WORDS; i++) begin
      sram_mem[i] = 32'h0;
      ref_mem[i]  = 32'h0;
    end
    test_reset();
    test_write_read();
    test_back_to_back();
    test_random();
    test_idle_retention();
    test_threshold();
    test_ret_disabled();
    test_reset_in_ret();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule
